// File: rtl/shift_left_branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_left_branch_pkg
//  Description : Shared CPU constants for the branch-offset scaling unit:
//                datapath width, default branch shift and a legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_left_branch_pkg;

   // 16-bit datapath, halfword-aligned instructions
   localparam int WORD_W       = 16;
   localparam int BRANCH_SHIFT = 1;

   // A shift must move at least one bit and leave at least one bit in place
   function automatic bit shift_legal(input int width, input int shift);
      return (shift >= 1) && (shift < width);
   endfunction

endpackage : shift_left_branch_pkg
`default_nettype wire

// File: rtl/shift_left_branch_comb.sv
`default_nettype none
// ============================================================================
//  Module      : shift_left_branch_comb
//  Description : Purely combinational branch-offset scaler. Shifts the
//                sign-extended offset left by SHIFT, flags bits lost off the
//                top and signed overflow, and forms pc + scaled offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_left_branch_comb
   import shift_left_branch_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int SHIFT = BRANCH_SHIFT
) (
   input  logic [WIDTH-1:0] i_branch,
   input  logic [WIDTH-1:0] i_pc,
   output logic [WIDTH-1:0] o_shift,
   output logic [WIDTH-1:0] o_target,
   output logic             o_lost,
   output logic             o_sovf
);

   // Reject shift amounts that would discard the whole word or do nothing
   if (!shift_legal(WIDTH, SHIFT)) begin : g_bad_shift
      $error("shift_left_branch_comb: SHIFT must be in 1..WIDTH-1");
   end

   // Top SHIFT+1 input bits: the SHIFT bits that fall off plus the new sign bit
   logic [SHIFT:0] w_top;

   // Logical shift, zero fill; the upper SHIFT bits are simply dropped
   assign o_shift  = i_branch << SHIFT;
   assign w_top    = i_branch[WIDTH-1 -: SHIFT+1];
   assign o_lost   = |i_branch[WIDTH-1 -: SHIFT];
   // Value survives as a signed number only if the discarded bits match the new sign
   assign o_sovf   = ~((&w_top) | (~|w_top));
   // Carry-out discarded: branch targets wrap modulo 2^WIDTH
   assign o_target = i_pc + o_shift;

endmodule : shift_left_branch_comb
`default_nettype wire

// File: rtl/shift_left_branch.sv
`default_nettype none
// ============================================================================
//  Module      : shift_left_branch
//  Description : Branch-offset scaling unit. Zero-latency shifted offset for
//                the single-cycle datapath plus a one-cycle registered copy
//                with overflow flags and branch target, qualified by valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_left_branch
   import shift_left_branch_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int SHIFT = BRANCH_SHIFT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Shift_Branch,
   output logic [WIDTH-1:0] Shift_Branch_out,
   input  logic [WIDTH-1:0] pc_in,
   input  logic             in_valid,
   output logic [WIDTH-1:0] target_q,
   output logic [WIDTH-1:0] shift_q,
   output logic             lost_q,
   output logic             sovf_q,
   output logic             out_valid
);

   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_target;
   logic             w_lost;
   logic             w_sovf;

   logic [WIDTH-1:0] shift_d;
   logic [WIDTH-1:0] target_d;
   logic             lost_d;
   logic             sovf_d;
   logic             out_valid_d;

   shift_left_branch_comb #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT)
   ) u_comb (
      .i_branch (Shift_Branch),
      .i_pc     (pc_in),
      .o_shift  (w_shift),
      .o_target (w_target),
      .o_lost   (w_lost),
      .o_sovf   (w_sovf)
   );

   // Combinational result bypasses the register stage entirely
   assign Shift_Branch_out = w_shift;

   // Next-state: capture on valid, otherwise hold data and drop valid
   always_comb begin
      shift_d     = shift_q;
      target_d    = target_q;
      lost_d      = lost_q;
      sovf_d      = sovf_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         shift_d  = w_shift;
         target_d = w_target;
         lost_d   = w_lost;
         sovf_d   = w_sovf;
      end
   end

   // Output register stage; reset wins over an incoming valid
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q   <= '0;
         target_q  <= '0;
         lost_q    <= 1'b0;
         sovf_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         target_q  <= target_d;
         lost_q    <= lost_d;
         sovf_q    <= sovf_d;
         out_valid <= out_valid_d;
      end
   end

endmodule : shift_left_branch
`default_nettype wire

// File: tb/tb_shift_left_branch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_left_branch
//  Description : Self-checking bench for shift_left_branch (16/1 and 8/2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_left_branch;

   logic        clk = 1'b0;
   logic        clk_run = 1'b0;
   logic        rst = 1'b1;
   logic        cmp_en = 1'b0;

   // Default 16-bit / shift-1 instance
   logic [15:0] sb16 = '0, pc16 = '0, out16, tgt16_q, sh16_q;
   logic        v16 = 1'b0, lost16_q, sovf16_q, ov16;
   // 8-bit / shift-2 instance
   logic [7:0]  sb8 = '0, pc8 = '0, out8, tgt8_q, sh8_q;
   logic        v8 = 1'b0, lost8_q, sovf8_q, ov8;

   int checks = 0;
   int errors = 0;

   // Bench model of the registered path
   longint e16_sh = 0, e16_tg = 0, e8_sh = 0, e8_tg = 0;
   bit     e16_l = 0, e16_o = 0, e16_v = 0, e8_l = 0, e8_o = 0, e8_v = 0;

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   shift_left_branch dut16 (
      .clk (clk), .rst (rst), .Shift_Branch (sb16), .Shift_Branch_out (out16),
      .pc_in (pc16), .in_valid (v16), .target_q (tgt16_q), .shift_q (sh16_q),
      .lost_q (lost16_q), .sovf_q (sovf16_q), .out_valid (ov16)
   );

   shift_left_branch #(.WIDTH(8), .SHIFT(2)) dut8 (
      .clk (clk), .rst (rst), .Shift_Branch (sb8), .Shift_Branch_out (out8),
      .pc_in (pc8), .in_valid (v8), .target_q (tgt8_q), .shift_q (sh8_q),
      .lost_q (lost8_q), .sovf_q (sovf8_q), .out_valid (ov8)
   );

   // ---- behavioural arithmetic model ----
   function automatic longint pw2(input int n);
      return longint'(1) << n;
   endfunction

   // Multiply by 2^s, keep the value modulo 2^w
   function automatic longint m_shift(input longint x, input int w, input int s);
      return (x * pw2(s)) % pw2(w);
   endfunction

   function automatic longint m_target(input longint pc, input longint x, input int w, input int s);
      return (pc + m_shift(x, w, s)) % pw2(w);
   endfunction

   // Any bit weighing 2^(w-s) or more falls off the top
   function automatic bit m_lost(input longint x, input int w, input int s);
      return (x / pw2(w - s)) != 0;
   endfunction

   // Signed value times 2^s no longer fits in w-bit two's complement
   function automatic bit m_sovf(input longint x, input int w, input int s);
      longint sx, p;
      sx = (x >= pw2(w - 1)) ? x - pw2(w) : x;
      p  = sx * pw2(s);
      return (p < -pw2(w - 1)) || (p >= pw2(w - 1));
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge from the values the DUT also samples
   always @(posedge clk) begin
      if (rst) begin
         e16_sh <= 0; e16_tg <= 0; e16_l <= 0; e16_o <= 0; e16_v <= 0;
         e8_sh  <= 0; e8_tg  <= 0; e8_l  <= 0; e8_o  <= 0; e8_v  <= 0;
      end else begin
         e16_v <= v16;
         if (v16) begin
            e16_sh <= m_shift(sb16, 16, 1);
            e16_tg <= m_target(pc16, sb16, 16, 1);
            e16_l  <= m_lost(sb16, 16, 1);
            e16_o  <= m_sovf(sb16, 16, 1);
         end
         e8_v <= v8;
         if (v8) begin
            e8_sh <= m_shift(sb8, 8, 2);
            e8_tg <= m_target(pc8, sb8, 8, 2);
            e8_l  <= m_lost(sb8, 8, 2);
            e8_o  <= m_sovf(sb8, 8, 2);
         end
      end
   end

   // Compare process: every falling edge once the registers are defined
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("comb16",   out16,    m_shift(sb16, 16, 1));
         chk("comb8",    out8,     m_shift(sb8, 8, 2));
         chk("valid16",  ov16,     e16_v);
         chk("shift16",  sh16_q,   e16_sh);
         chk("target16", tgt16_q,  e16_tg);
         chk("lost16",   lost16_q, e16_l);
         chk("sovf16",   sovf16_q, e16_o);
         chk("valid8",   ov8,      e8_v);
         chk("shift8",   sh8_q,    e8_sh);
         chk("target8",  tgt8_q,   e8_tg);
         chk("lost8",    lost8_q,  e8_l);
         chk("sovf8",    sovf8_q,  e8_o);
      end
   end

   // Apply inputs, then let one rising edge pass and settle
   task automatic step16(input logic [15:0] sb, input logic [15:0] pc, input logic v, input logic r);
      sb16 = sb; pc16 = pc; v16 = v; rst = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pick16();
      logic [15:0] edges [8];
      edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h4000, 16'hC000, 16'hBFFF};
      if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 7)];
      return 16'($urandom);
   endfunction

   initial begin
      // Combinational path with the clock stopped
      sb16 = 16'h0001; #10; chk("lit_comb_0001", out16, 16'h0002);
      sb16 = 16'h8000; #10; chk("lit_comb_8000", out16, 16'h0000);
      sb16 = 16'hFFFF; #10; chk("lit_comb_FFFF", out16, 16'hFFFE);
      sb16 = 16'h0000; #10; chk("lit_comb_0000", out16, 16'h0000);
      sb8  = 8'h3F;    #10; chk("lit_comb8_3F",  out8,  8'hFC);

      // Start clock under reset
      clk_run = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("lit_rst_valid",  ov16,    0);
      chk("lit_rst_shift",  sh16_q,  0);
      chk("lit_rst_target", tgt16_q, 0);
      chk("lit_rst_flags",  {lost16_q, sovf16_q}, 0);
      cmp_en = 1'b1;

      // Flags
      step16(16'h8000, 16'h0000, 1, 0); chk("lit_flags_8000", {lost16_q, sovf16_q}, 2'b11);
      step16(16'hFFFF, 16'h0000, 1, 0); chk("lit_flags_FFFF", {lost16_q, sovf16_q}, 2'b10);
      step16(16'h4000, 16'h0000, 1, 0); chk("lit_flags_4000", {lost16_q, sovf16_q}, 2'b01);
      step16(16'h0001, 16'h0000, 1, 0); chk("lit_flags_0001", {lost16_q, sovf16_q}, 2'b00);

      // Targets, including wrap-around
      step16(16'hFFFE, 16'h0010, 1, 0);
      chk("lit_tgt_neg", tgt16_q, 16'h000C);
      chk("lit_tgt_valid", ov16, 1);
      step16(16'h0002, 16'hFFFE, 1, 0); chk("lit_tgt_wrap", tgt16_q, 16'h0002);

      // Valid gating: hold data while in_valid is low
      step16(16'h0003, 16'h0100, 1, 0);
      step16(16'h1234, 16'h0100, 0, 0);
      chk("lit_gate_valid",  ov16,    0);
      chk("lit_gate_shift",  sh16_q,  16'h0006);
      chk("lit_gate_target", tgt16_q, 16'h0106);
      step16(16'h1234, 16'h0100, 1, 0);
      chk("lit_recap_shift",  sh16_q,  16'h2468);
      chk("lit_recap_target", tgt16_q, 16'h2568);

      // Reset wins over valid; combinational output keeps tracking
      step16(16'h00F0, 16'h1111, 1, 1);
      chk("lit_midrst_regs", {sh16_q, tgt16_q, lost16_q, sovf16_q, ov16}, 0);
      chk("lit_midrst_comb", out16, 16'h01E0);

      // 8-bit / shift-2 instance flags
      rst = 1'b0; sb8 = 8'h3F; pc8 = 8'h01; v8 = 1'b1;
      step16(16'h0000, 16'h0000, 0, 0);
      chk("lit8_shift", sh8_q, 8'hFC);
      chk("lit8_flags", {lost8_q, sovf8_q}, 2'b01);
      chk("lit8_target", tgt8_q, 8'hFD);

      // Randomized traffic, checked each cycle by the compare process
      for (int i = 0; i < 400; i++) begin
         sb8 = ($urandom_range(0, 3) == 0) ? 8'hC0 : 8'($urandom);
         pc8 = 8'($urandom);
         v8  = ($urandom_range(0, 3) != 0);
         step16(pick16(), 16'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_shift_left_branch
`default_nettype wire
